// File: rtl/ad1868_decoder.sv
// AD1868-style serial DAC stream decoder.
// Oversamples the asynchronous bit clock, data lines and latch strobes on
// i_mclk, reassembles each channel's IN_BITS-bit word, and presents the top
// 16 bits as signed PCM. Outputs mute if no latch edge is seen for TIMEOUT
// cycles.
module ad1868_decoder #(
  parameter int IN_BITS = 18,
  parameter int TIMEOUT = 24576
) (
  input  logic               i_mclk,
  input  logic               i_rst_x,
  input  logic               i_ck,
  input  logic               i_dl,
  input  logic               i_dr,
  input  logic               i_ll,
  input  logic               i_lr,
  output logic signed [15:0] o_data_l,
  output logic signed [15:0] o_data_r,
  output logic               o_valid_l,
  output logic               o_valid_r,
  output logic               o_active,
  output logic               o_err
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT);
  localparam logic [4:0]      BITS_REQ = 5'(IN_BITS);
  localparam logic [4:0]      CNT_SAT  = 5'd31;

  // Bit positions of the five asynchronous inputs in the synchronizer vectors.
  localparam int CK = 0;
  localparam int DL = 1;
  localparam int DR = 2;
  localparam int LL = 3;
  localparam int LR = 4;

  logic [4:0]         s1, s2, s3;
  logic               ck_rise, ll_rise, lr_rise;
  logic [IN_BITS-1:0] sr_l, sr_r, sr_l_nx, sr_r_nx;
  logic [4:0]         cnt_l, cnt_r, cnt_l_nx, cnt_r_nx;
  logic [TW-1:0]      to_cnt;
  logic               take_l, take_r, mute;

  // Two-flop synchronizers plus a third stage for edge detection; data lines
  // share the same depth so they stay aligned with the bit clock.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {i_lr, i_ll, i_dr, i_dl, i_ck};
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Registered rise pulses. The data bit for a registered ck rise is the s2
  // value of the detection cycle, which sits in s3 one cycle later.
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      ck_rise <= 1'b0;
      ll_rise <= 1'b0;
      lr_rise <= 1'b0;
    end else begin
      ck_rise <= s2[CK] & ~s3[CK];
      ll_rise <= s2[LL] & ~s3[LL];
      lr_rise <= s2[LR] & ~s3[LR];
    end
  end

  // Post-shift view of each channel, so a bit clock and latch landing in the
  // same cycle capture the new bit and count it.
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sr_l_nx  = sr_l;
    sr_r_nx  = sr_r;
    cnt_l_nx = cnt_l;
    cnt_r_nx = cnt_r;
    if (ck_rise) begin
      sr_l_nx = {sr_l[IN_BITS-2:0], s3[DL]};
      sr_r_nx = {sr_r[IN_BITS-2:0], s3[DR]};
      if (cnt_l != CNT_SAT) cnt_l_nx = cnt_l + 5'd1;
      if (cnt_r != CNT_SAT) cnt_r_nx = cnt_r + 5'd1;
    end
    take_l = ll_rise && (cnt_l_nx >= BITS_REQ);
    take_r = lr_rise && (cnt_r_nx >= BITS_REQ);
    // Mute exactly on the cycle the idle counter reaches TIMEOUT; a latch
    // edge in that cycle takes priority.
    mute   = !(ll_rise || lr_rise) && (to_cnt == TO_MAX - 1'b1);
  end

  // Shift registers, bit counters, idle timer and the registered outputs.
  always_ff @(posedge i_mclk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      sr_l      <= '0;
      sr_r      <= '0;
      cnt_l     <= '0;
      cnt_r     <= '0;
      to_cnt    <= '0;
      o_data_l  <= '0;
      o_data_r  <= '0;
      o_valid_l <= 1'b0;
      o_valid_r <= 1'b0;
      o_active  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      sr_l      <= sr_l_nx;
      sr_r      <= sr_r_nx;
      cnt_l     <= ll_rise ? 5'd0 : cnt_l_nx;
      cnt_r     <= lr_rise ? 5'd0 : cnt_r_nx;
      o_valid_l <= take_l;
      o_valid_r <= take_r;
      o_err     <= (ll_rise && !take_l) || (lr_rise && !take_r);

      if (ll_rise || lr_rise) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (take_l) begin
        o_data_l <= sr_l_nx[IN_BITS-1 -: 16];
      end else if (mute) begin
        o_data_l <= '0;
      end

      if (take_r) begin
        o_data_r <= sr_r_nx[IN_BITS-1 -: 16];
      end else if (mute) begin
        o_data_r <= '0;
      end

      if (take_l || take_r) begin
        o_active <= 1'b1;
      end else if (mute) begin
        o_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad1868_decoder.sv
// Directed testbench for ad1868_decoder with an expected-word scoreboard.
`timescale 1ns/1ps
module tb_ad1868_decoder;

  localparam int IN_BITS = 18;
  localparam int TIMEOUT = 24576;

  logic        i_mclk = 1'b0;
  logic        i_rst_x = 1'b0;
  logic        i_ck = 1'b0;
  logic        i_dl = 1'b0;
  logic        i_dr = 1'b0;
  logic        i_ll = 1'b0;
  logic        i_lr = 1'b0;
  logic [15:0] o_data_l, o_data_r;
  logic        o_valid_l, o_valid_r, o_active, o_err;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];

  ad1868_decoder #(.IN_BITS(IN_BITS), .TIMEOUT(TIMEOUT)) dut (
    .i_mclk    (i_mclk),
    .i_rst_x   (i_rst_x),
    .i_ck      (i_ck),
    .i_dl      (i_dl),
    .i_dr      (i_dr),
    .i_ll      (i_ll),
    .i_lr      (i_lr),
    .o_data_l  (o_data_l),
    .o_data_r  (o_data_r),
    .o_valid_l (o_valid_l),
    .o_valid_r (o_valid_r),
    .o_active  (o_active),
    .o_err     (o_err)
  );

  always #20 i_mclk = ~i_mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_mclk);
  endtask

  // Shift the low n bits of each word, MSB first, one bit per i_ck period.
  task automatic send_bits(input logic [23:0] wl, input logic [23:0] wr, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      i_dl = wl[i];
      i_dr = wr[i];
      i_ck = 1'b0;
      wait_cyc(4);
      i_ck = 1'b1;
      wait_cyc(4);
      i_ck = 1'b0;
    end
    wait_cyc(4);
  endtask

  task automatic latch(input logic l, input logic r);
    i_ll = l;
    i_lr = r;
    wait_cyc(4);
    i_ll = 1'b0;
    i_lr = 1'b0;
    wait_cyc(8);
  endtask

  // Scoreboard: every valid pulse must match the next expected word.
  always @(negedge i_mclk) begin
    if (o_valid_l) begin
      if (exp_l.size() == 0) check("valid_l_unexpected", 32'd1, 32'd0);
      else check("data_l", {16'h0, o_data_l}, {16'h0, exp_l.pop_front()});
    end
    if (o_valid_r) begin
      if (exp_r.size() == 0) check("valid_r_unexpected", 32'd1, 32'd0);
      else check("data_r", {16'h0, o_data_r}, {16'h0, exp_r.pop_front()});
    end
    if (o_err) err_seen++;
  end

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] wl, wr;
    bit          seen;

    // Reset state
    wait_cyc(3);
    check("rst_data_l", {16'h0, o_data_l}, 32'h0);
    check("rst_data_r", {16'h0, o_data_r}, 32'h0);
    check("rst_flags", {28'h0, o_valid_l, o_valid_r, o_active, o_err}, 32'h0);
    i_rst_x = 1'b1;
    wait_cyc(4);

    // Left 18'h24680 with exact latency check: valid at edge 3
    exp_l.push_back(16'h91A0);
    send_bits(24'h024680, 24'h0, 18);
    i_ll = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge i_mclk);
      @(negedge i_mclk);
      check("lat_quiet", {31'h0, o_valid_l}, 32'h0);
    end
    @(posedge i_mclk);
    @(negedge i_mclk);
    check("lat_valid", {31'h0, o_valid_l}, 32'h1);
    check("lat_data", {16'h0, o_data_l}, 32'h91A0);
    check("lat_active", {31'h0, o_active}, 32'h1);
    wait_cyc(2);
    i_ll = 1'b0;
    wait_cyc(8);
    check("err_after_first", err_seen, 32'd0);

    // Right -1 then most negative; left unchanged
    exp_r.push_back(16'hFFFF);
    send_bits(24'h0, 24'h03FFFF, 18);
    latch(1'b0, 1'b1);
    exp_r.push_back(16'h8000);
    send_bits(24'h0, 24'h020000, 18);
    latch(1'b0, 1'b1);
    check("data_r_neg", {16'h0, o_data_r}, 32'h8000);
    check("data_l_hold", {16'h0, o_data_l}, 32'h91A0);

    // Short right word rejected, then a full word accepted
    send_bits(24'h0, 24'h0003FF, 10);
    latch(1'b0, 1'b1);
    check("short_err", err_seen, 32'd1);
    check("short_hold_r", {16'h0, o_data_r}, 32'h8000);
    exp_r.push_back(16'h48D1);
    send_bits(24'h0, 24'h012345, 18);
    latch(1'b0, 1'b1);
    check("after_short_r", {16'h0, o_data_r}, 32'h48D1);

    // 20 bits 1,1,0,17 ones: only the last 18 bits count
    exp_l.push_back(16'h7FFF);
    send_bits(24'h0DFFFF, 24'h0, 20);
    latch(1'b1, 1'b0);
    check("overlong_l", {16'h0, o_data_l}, 32'h7FFF);

    // Final ck rise in the same cycle as both latch rises
    wl = 24'h02AAAB;
    wr = 24'h00FFFC;
    exp_l.push_back(16'hAAAA);
    exp_r.push_back(16'h3FFF);
    send_bits(wl >> 1, wr >> 1, 17);
    i_dl = wl[0];
    i_dr = wr[0];
    i_ck = 1'b0;
    wait_cyc(4);
    i_ck = 1'b1;
    i_ll = 1'b1;
    i_lr = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge i_mclk);
      if (o_valid_l) seen = 1'b1;
    end
    check("simul_valid_seen", {31'h0, seen}, 32'h1);
    check("simul_valid_r", {31'h0, o_valid_r}, 32'h1);
    i_ck = 1'b0;
    i_ll = 1'b0;
    i_lr = 1'b0;
    check("simul_no_err", err_seen, 32'd1);

    // Idle until timeout: last latch processed at edge V, mute at V+TIMEOUT
    repeat (TIMEOUT - 1) @(posedge i_mclk);
    @(negedge i_mclk);
    check("pre_timeout_active", {31'h0, o_active}, 32'h1);
    check("pre_timeout_data_l", {16'h0, o_data_l}, 32'hAAAA);
    @(posedge i_mclk);
    @(negedge i_mclk);
    check("timeout_active", {31'h0, o_active}, 32'h0);
    check("timeout_data_l", {16'h0, o_data_l}, 32'h0);
    check("timeout_data_r", {16'h0, o_data_r}, 32'h0);
    exp_l.push_back(16'h91A0);
    send_bits(24'h024680, 24'h0, 18);
    latch(1'b1, 1'b0);
    check("restore_active", {31'h0, o_active}, 32'h1);
    check("restore_data_r", {16'h0, o_data_r}, 32'h0);

    // Reset in the middle of a word
    send_bits(24'h03FFFF >> 9, 24'h0, 9);
    i_rst_x = 1'b0;
    #1;
    check("midrst_data_l", {16'h0, o_data_l}, 32'h0);
    check("midrst_active", {31'h0, o_active}, 32'h0);
    wait_cyc(3);
    i_rst_x = 1'b1;
    wait_cyc(2);
    send_bits(24'h0001FF, 24'h0, 9);
    latch(1'b1, 1'b0);
    check("midrst_err", err_seen, 32'd2);
    check("midrst_hold_l", {16'h0, o_data_l}, 32'h0);
    exp_l.push_back(16'h91A0);
    send_bits(24'h024680, 24'h0, 18);
    latch(1'b1, 1'b0);
    check("midrst_recover", {16'h0, o_data_l}, 32'h91A0);

    check("exp_l_drained", exp_l.size(), 32'd0);
    check("exp_r_drained", exp_r.size(), 32'd0);
    check("err_total", err_seen, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
